instruction_fetch_queue: RTL and testbench

//  Parametrised IF stage: owns the PC and issues word-addressed fetches to a synchronous imem with 1-cycle read latency.

---
 rtl/instruction_fetch_queue.sv | 134 +++++++++++++
 tb/tb_instruction_fetch_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency imem reads and buffers
// returned words with their PCs in a small prefetch queue drained over valid/ready.
module instruction_fetch_queue #(
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_pc_sel,
    input  logic [ADDR_W-1:0]          in_pc_jump,
    input  logic                       stop_debug,
    input  logic                       load_program,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [DATA_W-1:0]          prog_data,
    input  logic                       prog_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       imem_re,
    output logic                       imem_we,
    output logic [DATA_W-1:0]          imem_wdata,
    input  logic [DATA_W-1:0]          imem_rdata,
    output logic                       out_valid,
    input  logic                       in_ready,
    output logic [DATA_W-1:0]          out_instruction,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     out_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic          flush;
    logic          issue_ok;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic [CntW:0] occupancy;

    // Credit check counts the in-flight read but not a same-cycle pop, so a push never overflows.
    assign occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    assign not_empty = (count_q != '0);
    assign flush     = load_program | in_pc_sel;
    assign issue_ok  = !rst && !load_program && !stop_debug && !in_pc_sel &&
                       (occupancy < (CntW + 1)'(DEPTH));
    assign push      = inflight_q & !flush;
    assign out_valid = not_empty & !stop_debug;
    assign pop       = out_valid & in_ready & !flush;

    assign imem_addr       = load_program ? prog_addr : pc_q;
    assign imem_re         = issue_ok;
    assign imem_we         = load_program & prog_we & !rst;
    assign imem_wdata      = prog_data;
    assign out_count       = count_q;
    assign out_instruction = not_empty ? instr_mem_q[head_q] : '0;
    assign out_pc          = not_empty ? pc_mem_q[head_q] : '0;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = issue_ok;

        if (issue_ok) begin
            req_pc_d = pc_q;
        end

        if (load_program) begin
            pc_d    = RESET_PC;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (in_pc_sel) begin
            pc_d    = in_pc_jump;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_ok) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PtrW'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            instr_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench: a 32-bit-address instance for the main scenarios and a 4-bit-address
// instance for PC wrap, each backed by its own 1-cycle-latency memory model.
module tb_instruction_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_pc_sel;
    logic [31:0] in_pc_jump;
    logic        stop_debug;
    logic        load_program;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_we;
    logic        in_ready;

    logic [31:0] imem_addr1, imem_wdata1, imem_rdata1, out_instruction1, out_pc1;
    logic        imem_re1, imem_we1, out_valid1;
    logic [2:0]  out_count1;

    logic [3:0]  imem_addr2, out_pc2;
    logic [31:0] imem_wdata2, imem_rdata2, out_instruction2;
    logic        imem_re2, imem_we2, out_valid2;
    logic [2:0]  out_count2;

    logic        mem_init;
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [16];

    int checks;
    int errors;

    instruction_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .RESET_PC(32'd0)) dut1 (
        .clk(clk), .rst(rst), .in_pc_sel(in_pc_sel), .in_pc_jump(in_pc_jump),
        .stop_debug(stop_debug), .load_program(load_program), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_we(prog_we), .imem_addr(imem_addr1), .imem_re(imem_re1),
        .imem_we(imem_we1), .imem_wdata(imem_wdata1), .imem_rdata(imem_rdata1),
        .out_valid(out_valid1), .in_ready(in_ready), .out_instruction(out_instruction1),
        .out_pc(out_pc1), .out_count(out_count1)
    );

    instruction_fetch_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4), .RESET_PC(4'd0)) dut2 (
        .clk(clk), .rst(rst), .in_pc_sel(in_pc_sel), .in_pc_jump(in_pc_jump[3:0]),
        .stop_debug(stop_debug), .load_program(load_program), .prog_addr(prog_addr[3:0]),
        .prog_data(prog_data), .prog_we(prog_we), .imem_addr(imem_addr2), .imem_re(imem_re2),
        .imem_we(imem_we2), .imem_wdata(imem_wdata2), .imem_rdata(imem_rdata2),
        .out_valid(out_valid2), .in_ready(in_ready), .out_instruction(out_instruction2),
        .out_pc(out_pc2), .out_count(out_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'h100 + 32'(i);
            for (int i = 0; i < 16; i++) mem2[i] <= 32'h200 + 32'(i);
        end else begin
            if (imem_we1) mem1[imem_addr1[7:0]] <= imem_wdata1;
            if (imem_re1) imem_rdata1 <= mem1[imem_addr1[7:0]];
            if (imem_we2) mem2[imem_addr2] <= imem_wdata2;
            if (imem_re2) imem_rdata2 <= mem2[imem_addr2];
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench at a negedge with rst still high after one reset edge.
    task automatic do_reset(input logic rdy);
        step();
        rst = 1'b1; in_pc_sel = 1'b0; in_pc_jump = '0; stop_debug = 1'b0;
        load_program = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; in_ready = rdy;
        step();
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        load_program = 1'b1; prog_we = 1'b1;
        #1;
        checks++;
        if ({out_valid1, out_count1, out_pc1, out_instruction1, imem_re1, imem_we1} !==
            {1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got v=%b cnt=%0d pc=%h ins=%h re=%b we=%b want all 0",
                     out_valid1, out_count1, out_pc1, out_instruction1, imem_re1, imem_we1);
        end
        load_program = 1'b0; prog_we = 1'b0;
    endtask

    task automatic test_free_run();
        do_reset(1'b1);
        step(); rst = 1'b0; #1;
        checks++;
        if ({imem_re1, imem_addr1, out_valid1} !== {1'b1, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL first_issue got re=%b addr=%h v=%b want re=1 addr=0 v=0",
                     imem_re1, imem_addr1, out_valid1);
        end
        step(); #1;
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL latency_gap got v=%b want 0", out_valid1);
        end
        for (int i = 0; i < 8; i++) begin
            step(); #1;
            checks++;
            if ({out_valid1, out_pc1, out_instruction1} !== {1'b1, 32'(i), 32'h100 + 32'(i)}) begin
                errors++;
                $display("FAIL free_run[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i,
                         out_valid1, out_pc1, out_instruction1, i, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        step(); rst = 1'b0;
        for (int i = 1; i < 10; i++) step();
        #1;
        checks++;
        if ({out_count1, imem_re1, out_valid1, out_pc1, out_instruction1} !==
            {3'd4, 1'b0, 1'b1, 32'd0, 32'h100}) begin
            errors++;
            $display("FAIL stall_full got cnt=%0d re=%b v=%b pc=%h ins=%h want 4 0 1 0 100",
                     out_count1, imem_re1, out_valid1, out_pc1, out_instruction1);
        end
        for (int j = 0; j < 8; j++) begin
            step(); in_ready = 1'b1; #1;
            checks++;
            if ({out_valid1, out_pc1, out_instruction1} !== {1'b1, 32'(j), 32'h100 + 32'(j)}) begin
                errors++;
                $display("FAIL resume[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h", j,
                         out_valid1, out_pc1, out_instruction1, j);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        step(); rst = 1'b0;
        for (int i = 1; i < 4; i++) step();
        step(); in_pc_sel = 1'b1; in_pc_jump = 32'h40; #1;
        checks++;
        if ({out_count1, imem_re1} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL pre_redirect got cnt=%0d re=%b want cnt=3 re=0", out_count1, imem_re1);
        end
        step(); in_pc_sel = 1'b0; in_ready = 1'b1; #1;
        checks++;
        if ({out_valid1, out_count1, imem_re1, imem_addr1} !== {1'b0, 3'd0, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL redirect_flush got v=%b cnt=%0d re=%b addr=%h want 0 0 1 40",
                     out_valid1, out_count1, imem_re1, imem_addr1);
        end
        step(); #1;
        checks++;
        if (out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL redirect_stale got v=%b pc=%h want v=0", out_valid1, out_pc1);
        end
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            checks++;
            if ({out_valid1, out_pc1, out_instruction1} !==
                {1'b1, 32'h40 + 32'(k), 32'h140 + 32'(k)}) begin
                errors++;
                $display("FAIL redirect_seq[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h", k,
                         out_valid1, out_pc1, out_instruction1, 32'h40 + 32'(k));
            end
        end
    endtask

    task automatic test_stop_debug();
        do_reset(1'b1);
        step(); rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checks++;
            if ({out_valid1, out_pc1} !== {1'b1, 32'(i)}) begin
                errors++;
                $display("FAIL pre_stop[%0d] got v=%b pc=%h want v=1 pc=%h", i,
                         out_valid1, out_pc1, i);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(); stop_debug = 1'b1; #1;
            checks++;
            if ({imem_re1, out_valid1, imem_addr1} !== {1'b0, 1'b0, 32'd5}) begin
                errors++;
                $display("FAIL stopped[%0d] got re=%b v=%b addr=%h want re=0 v=0 addr=5", i,
                         imem_re1, out_valid1, imem_addr1);
            end
        end
        checks++;
        if (out_count1 !== 3'd2) begin
            errors++;
            $display("FAIL stop_count got %0d want 2", out_count1);
        end
        for (int k = 0; k < 4; k++) begin
            step(); stop_debug = 1'b0; #1;
            checks++;
            if ({out_valid1, out_pc1, out_instruction1} !==
                {1'b1, 32'd3 + 32'(k), 32'h103 + 32'(k)}) begin
                errors++;
                $display("FAIL post_stop[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h", k,
                         out_valid1, out_pc1, out_instruction1, 32'd3 + 32'(k));
            end
        end
    endtask

    task automatic test_load_program();
        do_reset(1'b1);
        step(); rst = 1'b0; load_program = 1'b1; prog_we = 1'b1;
        prog_addr = 32'd7; prog_data = 32'hDEADBEEF; #1;
        checks++;
        if ({imem_we1, imem_re1, imem_addr1, imem_wdata1} !==
            {1'b1, 1'b0, 32'd7, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_write got we=%b re=%b addr=%h wd=%h want 1 0 7 deadbeef",
                     imem_we1, imem_re1, imem_addr1, imem_wdata1);
        end
        step(); prog_we = 1'b0; prog_addr = '0; #1;
        checks++;
        if ({imem_we1, imem_re1, out_count1} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL load_idle got we=%b re=%b cnt=%0d want 0 0 0",
                     imem_we1, imem_re1, out_count1);
        end
        step(); load_program = 1'b0; #1;
        checks++;
        if ({imem_re1, imem_addr1} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL load_restart got re=%b addr=%h want re=1 addr=0", imem_re1, imem_addr1);
        end
        step();
        step(); #1;
        checks++;
        if ({out_valid1, out_pc1, out_instruction1} !== {1'b1, 32'd0, 32'h100}) begin
            errors++;
            $display("FAIL load_first got v=%b pc=%h ins=%h want 1 0 100",
                     out_valid1, out_pc1, out_instruction1);
        end
        step(); in_pc_sel = 1'b1; in_pc_jump = 32'd7;
        step(); in_pc_sel = 1'b0;
        step();
        step(); #1;
        checks++;
        if ({out_valid1, out_pc1, out_instruction1} !== {1'b1, 32'd7, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_readback got v=%b pc=%h ins=%h want 1 7 deadbeef",
                     out_valid1, out_pc1, out_instruction1);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [3:0] exp_pc [4];
        exp_pc[0] = 4'd14; exp_pc[1] = 4'd15; exp_pc[2] = 4'd0; exp_pc[3] = 4'd1;
        do_reset(1'b1);
        step(); rst = 1'b0; in_pc_sel = 1'b1; in_pc_jump = 32'd14;
        step(); in_pc_sel = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            checks++;
            if ({out_valid2, out_pc2, out_instruction2} !==
                {1'b1, exp_pc[k], 32'h200 + 32'(exp_pc[k])}) begin
                errors++;
                $display("FAIL wrap[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h", k,
                         out_valid2, out_pc2, out_instruction2, exp_pc[k]);
            end
        end
        step(); rst = 1'b1; #1;
        checks++;
        if ({imem_re1, imem_re2} !== 2'b00) begin
            errors++;
            $display("FAIL rst_issue got re1=%b re2=%b want 0 0", imem_re1, imem_re2);
        end
        step(); #1;
        checks++;
        if ({out_valid1, out_count1, out_pc1, out_instruction1,
             out_valid2, out_count2, out_pc2, out_instruction2} !==
            {1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL rst_mid got v=%b/%b cnt=%0d/%0d pc=%h/%h want all 0",
                     out_valid1, out_valid2, out_count1, out_count2, out_pc1, out_pc2);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        mem_init = 1'b1;
        rst = 1'b1; in_pc_sel = 1'b0; in_pc_jump = '0; stop_debug = 1'b0;
        load_program = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; in_ready = 1'b0;
        @(posedge clk);
        #1 mem_init = 1'b0;
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_stop_debug();
        test_load_program();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
